// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames from hps_io, folds E0/F0
// prefixes into key events and queues them in a small FIFO (valid/ready).
//
// Ports:
//   clk_sys, reset_n           system clock, async active-low reset
//   ps2_kbd_clk, ps2_kbd_data  raw PS/2 lines from hps_io (idle high)
//   key_valid/key_ready        FIFO head handshake
//   key_code/key_ext/key_release  registered head event
//   frame_err                  one-cycle pulse on a bad or aborted frame
//   overflow, status_clr       sticky drop flag and its synchronous clear

module ps2_kbd_rx #(
    parameter int FIFO_BITS = 3,
    parameter int TIMEOUT   = 20000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       frame_err,
    output logic       overflow,
    input  logic       status_clr
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int PW    = FIFO_BITS + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DECODE
    } state_t;

    // Synchronisers; reset to the idle-high level so no false edge follows reset
    logic clk_m_q;
    logic clk_s_q;
    logic clk_p_q;
    logic dat_m_q;
    logic dat_s_q;
    logic fall;

    assign fall = clk_p_q & ~clk_s_q;

    // Deframer state
    state_t          state_q,   state_d;
    logic [7:0]      sr_q,      sr_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            par_q,     par_d;
    logic            ext_q,     ext_d;
    logic            brk_q,     brk_d;
    logic [WD_W-1:0] wd_q,      wd_d;
    logic            err_q,     err_d;
    logic            timeout;
    logic            push;
    logic [9:0]      push_data;

    // FIFO state
    logic [9:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_q,    wr_d;
    logic [PW-1:0]   rd_q,    rd_d;
    logic            valid_q, valid_d;
    logic [9:0]      head_q,  head_d;
    logic            ovf_q,   ovf_d;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;

    assign push_data = {brk_q, ext_q, sr_q};

    // Abort only frames that are actually in flight
    assign timeout = ((state_q == S_DATA) ||
                      (state_q == S_PARITY) ||
                      (state_q == S_STOP)) &&
                     (wd_q == WD_W'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        err_d     = 1'b0;
        push      = 1'b0;

        if ((state_q == S_IDLE) || fall || timeout) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (fall && !dat_s_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    sr_d      = {dat_s_q, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = dat_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    // Odd parity over data plus parity bit
                    if (dat_s_q && (^{sr_q, par_q})) begin
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        ext_d   = 1'b0;
                        brk_d   = 1'b0;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (sr_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (sr_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    // FIFO control; extra pointer bit separates full from empty
    assign pop  = valid_q & key_ready;
    assign full = (wr_q[FIFO_BITS] != rd_q[FIFO_BITS]) &&
                  (wr_q[FIFO_BITS-1:0] == rd_q[FIFO_BITS-1:0]);
    // A pop in the same cycle frees the slot being written
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(pop);
        valid_d = (wr_d != rd_d);

        // Head register looks ahead; a push into an empty slot bypasses memory
        if (!valid_d) begin
            head_d = '0;
        end else if (push_ok && (rd_d == wr_q)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_d[FIFO_BITS-1:0]];
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (status_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem_q[wr_q[FIFO_BITS-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_m_q   <= 1'b1;
            clk_s_q   <= 1'b1;
            clk_p_q   <= 1'b1;
            dat_m_q   <= 1'b1;
            dat_s_q   <= 1'b1;
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            head_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            clk_m_q   <= ps2_kbd_clk;
            clk_s_q   <= clk_m_q;
            clk_p_q   <= clk_s_q;
            dat_m_q   <= ps2_kbd_data;
            dat_s_q   <= dat_m_q;
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            ovf_q     <= ovf_d;
        end
    end

    assign key_valid   = valid_q;
    assign key_release = head_q[9];
    assign key_ext     = head_q[8];
    assign key_code    = head_q[7:0];
    assign frame_err   = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: expected events queued at send time,
// popped events recorded by a monitor and compared against the queue.

module tb_ps2_kbd_rx;

    localparam int TIMEOUT = 20000;
    localparam int HALF    = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready = 1'b0;
    logic       status_clr = 1'b0;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_BITS(3),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .ps2_kbd_clk (ps2_clk),
        .ps2_kbd_data(ps2_data),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .status_clr  (status_clr)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: records popped events, error pulses and key_valid rises
    logic [9:0] obs_mem [256];
    int         obs_n = 0;
    int         err_cnt = 0;
    int         rise_cyc = -1;
    logic       prev_v = 1'b0;

    always @(negedge clk) begin
        if (key_valid && key_ready && obs_n < 256) begin
            obs_mem[obs_n] = {key_release, key_ext, key_code};
            obs_n++;
        end
        if (frame_err) err_cnt++;
        if (key_valid && !prev_v) rise_cyc = cyc;
        prev_v = key_valid;
    end

    int         total = 0;
    int         bad = 0;
    int         rd_idx = 0;
    int         stop_cyc = 0;
    logic [9:0] exp_q[$];
    logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                              8'h35, 8'h3C, 8'h43, 8'h44};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b, input logic is_stop);
        ps2_data = b;
        settle(HALF);
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        settle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input logic par_flip = 1'b0,
                              input logic stop_b = 1'b1,
                              input int nbits = 11);
        logic [10:0] f;
        f = {stop_b, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == 10);
    endtask

    task automatic compare_events();
        while (rd_idx < obs_n) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL extra_event observed=0x%0h expected=none",
                       obs_mem[rd_idx]);
            end else begin
                chk("event", obs_mem[rd_idx], exp_q.pop_front());
            end
            rd_idx++;
        end
    endtask

    task automatic check_drained(input string tag);
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int e0;
        int waited;

        settle(3);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ext", key_ext, 0);
        chk("rst_rel", key_release, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        settle(5);

        // Single make code, latency from stop-bit fall
        key_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C);
        settle(20);
        compare_events();
        chk("latency", rise_cyc - stop_cyc, 4);
        check_drained("t1_drained");

        // Prefix folding
        send_frame(8'hF0);
        settle(20);
        chk("prefix_no_event", obs_n, 1);
        exp_q.push_back({2'b10, 8'h1C});
        send_frame(8'h1C);
        send_frame(8'hE0);
        send_frame(8'hF0);
        exp_q.push_back({2'b11, 8'h75});
        send_frame(8'h75);
        settle(20);
        compare_events();
        check_drained("t2_drained");

        // Parity error, then recovery
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        settle(20);
        chk("parity_err", err_cnt - e0, 1);
        chk("parity_no_event", obs_n, 3);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C);
        settle(20);
        compare_events();
        check_drained("t3_drained");

        // Bad stop bit after E0 clears the pending prefix
        send_frame(8'hE0);
        e0 = err_cnt;
        send_frame(8'h74, 1'b0, 1'b0);
        settle(20);
        chk("stop_err", err_cnt - e0, 1);
        exp_q.push_back({2'b00, 8'h74});
        send_frame(8'h74);
        settle(20);
        compare_events();
        check_drained("stop_drained");

        // FIFO fill and overflow
        key_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back({2'b00, codes[i]});
            send_frame(codes[i]);
            if (i == 7) begin
                settle(10);
                chk("ovf_before_9th", overflow, 0);
            end
        end
        settle(10);
        chk("ovf_set", overflow, 1);
        chk("full_valid", key_valid, 1);
        chk("head_first", key_code, 8'h15);
        settle(50);
        chk("head_stable", key_code, 8'h15);
        key_ready = 1'b1;
        settle(30);
        compare_events();
        check_drained("t4_drained");
        chk("drain_empty", key_valid, 0);
        chk("ovf_sticky", overflow, 1);
        status_clr = 1'b1;
        settle(1);
        status_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Watchdog abort of a stalled frame
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        waited = 0;
        while (err_cnt == e0 && waited < TIMEOUT + 100) begin
            settle(1);
            waited++;
        end
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_not_early", waited >= TIMEOUT - 20, 1);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C);
        settle(20);
        compare_events();
        check_drained("t5_drained");

        // Reset mid-frame with events queued
        key_ready = 1'b0;
        send_frame(8'h16);
        send_frame(8'h1E);
        send_frame(8'h26);
        settle(10);
        chk("pre_rst_valid", key_valid, 1);
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        settle(3);
        reset_n = 1'b1;
        settle(5);
        chk("post_rst_valid", key_valid, 0);
        key_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h5A);
        settle(20);
        compare_events();
        check_drained("t6_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
